fb_sram_arbiter: RTL and testbench

//  Shares one single-port synchronous framebuffer SRAM between display scan-out and a host port.

---
 rtl/fb_sram_arbiter_pkg.sv | 20 ++
 rtl/video_delay_line.sv | 33 +++
 rtl/fb_sram_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_fb_sram_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_sram_arbiter_pkg.sv
// Shared definitions for the framebuffer SRAM arbiter: host FSM encodings,
// colour field offsets within a pixel word, and the colour-bar table.
package fb_sram_arbiter_pkg;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_RD   = 2'd1,
        H_DONE = 2'd2
    } host_state_e;

    localparam int RED_LSB = 6;
    localparam int GRN_LSB = 3;
    localparam int BLU_LSB = 0;

    // Bar k expands each index bit across one 3-bit colour field.
    function automatic logic [8:0] bar_colour(input logic [2:0] k);
        return {{3{k[2]}}, {3{k[1]}}, {3{k[0]}}};
    endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register that re-times the video sync/blank strobes so
// they stay aligned with pixel data leaving the SRAM read pipeline.
module video_delay_line
    import fb_sram_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift chain: stage 0 takes the input, later stages follow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/fb_sram_arbiter.sv
// Shares one single-port framebuffer SRAM between display scan-out (owns it in
// active video) and a four-phase host port (served in blanking).
// Optional colour-bar generator under `TEST_PATTERN_EN.
module fb_sram_arbiter
    import fb_sram_arbiter_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 9
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              blank,
`ifdef TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              blank_o,
    output logic [2:0]        red,
    output logic [2:0]        green,
    output logic [2:0]        blue,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    host_state_e       state_r;
    host_state_e       state_s;
    logic              host_issue_s;
    logic              disp_rd_s;
    logic              disp_rd_d1_r;
    logic              vsync_prev_r;
    logic [ADDR_W-1:0] fb_addr_r;
    logic [DATA_W-1:0] pixel_r;
    logic [DATA_W-1:0] fill_s;
    logic [DATA_W-1:0] host_rdata_r;
    logic              host_ack_r;

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int COL_W = $clog2(BAR_W + 1);

    logic [COL_W-1:0]  col_r;
    logic [2:0]        bar_r;
    logic              blank_prev_r;
    logic [DATA_W-1:0] pattern_d1_r;

    assign disp_rd_s = ~blank & ~pattern_sel;
    assign fill_s    = pattern_d1_r;

    // Column/bar counters restart on every blank rise; bar colour is staged one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_r        <= {COL_W{1'b0}};
            bar_r        <= 3'd0;
            blank_prev_r <= 1'b0;
            pattern_d1_r <= {DATA_W{1'b0}};
        end else begin
            blank_prev_r <= blank;
            pattern_d1_r <= (pattern_sel & ~blank) ? bar_colour(bar_r) : {DATA_W{1'b0}};
            if (blank & ~blank_prev_r) begin
                col_r <= {COL_W{1'b0}};
                bar_r <= 3'd0;
            end else if (~blank && (col_r == COL_W'(BAR_W - 1))) begin
                col_r <= {COL_W{1'b0}};
                bar_r <= bar_r + 3'd1;
            end else if (~blank) begin
                col_r <= col_r + COL_W'(1'b1);
            end else begin
                col_r <= col_r;
            end
        end
    end
`else
    assign disp_rd_s = ~blank;
    assign fill_s    = {DATA_W{1'b0}};
`endif

    // Host FSM next state; a host op only issues in a slot the display does not claim.
    always_comb begin
        state_s      = state_r;
        host_issue_s = 1'b0;
        case (state_r)
            H_IDLE: begin
                if (!disp_rd_s && host_req) begin
                    host_issue_s = 1'b1;
                    state_s      = host_we ? H_DONE : H_RD;
                end else begin
                    state_s = H_IDLE;
                end
            end
            H_RD: begin
                state_s = H_DONE;
            end
            H_DONE: begin
                if (!host_req) begin
                    state_s = H_IDLE;
                end else begin
                    state_s = H_DONE;
                end
            end
            default: begin
                state_s = H_IDLE;
            end
        endcase
    end

    // SRAM strobes: display has priority, then a host issue, otherwise idle.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = host_addr;
        sram_wdata = host_wdata;
        if (!reset_n) begin
            sram_en = 1'b0;
        end else if (disp_rd_s) begin
            sram_en   = 1'b1;
            sram_addr = fb_addr_r;
        end else if (host_issue_s) begin
            sram_en = 1'b1;
            sram_we = host_we;
        end else begin
            sram_en = 1'b0;
        end
    end

    // Host FSM state, acknowledge and read-data capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= H_IDLE;
            host_ack_r   <= 1'b0;
            host_rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_s;
            host_ack_r <= (state_s == H_DONE);
            if (state_r == H_RD) begin
                host_rdata_r <= sram_rdata;
            end else begin
                host_rdata_r <= host_rdata_r;
            end
        end
    end

    // Scan-out address: vsync rise beats an increment landing in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vsync_prev_r <= 1'b0;
            fb_addr_r    <= {ADDR_W{1'b0}};
        end else begin
            vsync_prev_r <= vsync;
            if (vsync && !vsync_prev_r) begin
                fb_addr_r <= {ADDR_W{1'b0}};
            end else if (disp_rd_s) begin
                fb_addr_r <= (fb_addr_r == LAST_ADDR) ? {ADDR_W{1'b0}}
                                                      : fb_addr_r + ADDR_W'(1'b1);
            end else begin
                fb_addr_r <= fb_addr_r;
            end
        end
    end

    // Pixel pipeline: read issued at t, data on the bus at t+1, registered at t+2.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            disp_rd_d1_r <= 1'b0;
            pixel_r      <= {DATA_W{1'b0}};
        end else begin
            disp_rd_d1_r <= disp_rd_s;
            pixel_r      <= disp_rd_d1_r ? sram_rdata : fill_s;
        end
    end

    video_delay_line #(
        .DEPTH (2),
        .WIDTH (3)
    ) u_sync_delay (
        .clock   (clock),
        .reset_n (reset_n),
        .d       ({hsync, vsync, blank}),
        .q       ({hsync_o, vsync_o, blank_o})
    );

    assign red        = pixel_r[RED_LSB +: 3];
    assign green      = pixel_r[GRN_LSB +: 3];
    assign blue       = pixel_r[BLU_LSB +: 3];
    assign host_ack   = host_ack_r;
    assign host_rdata = host_rdata_r;

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Self-checking bench for fb_sram_arbiter on a small 16x4 frame: a reference
// model of scan-out and host handshakes checks every cycle, plus literal pins.
module tb_fb_sram_arbiter;

    localparam int H_ACT  = 16;
    localparam int V_ACT  = 4;
    localparam int H_TOT  = 22;
    localparam int V_TOT  = 7;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 9;
    localparam int WORDS  = H_ACT * V_ACT;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              hsync = 1'b0;
    logic              vsync = 1'b0;
    logic              blank = 1'b1;
    logic              hsync_o, vsync_o, blank_o;
    logic [2:0]        red, green, blue;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              sram_en, sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hc = 0;
    int vc = 0;

    fb_sram_arbiter #(
        .H_ACTIVE (H_ACT),
        .V_ACTIVE (V_ACT),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank      (blank),
`ifdef TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o),
        .blank_o    (blank_o),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // VGA-style timing source
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (hc == H_TOT - 1) begin
                hc = 0;
                vc = (vc == V_TOT - 1) ? 0 : vc + 1;
            end else begin
                hc = hc + 1;
            end
            blank = !((hc < H_ACT) && (vc < V_ACT));
            hsync = (hc >= 17) && (hc < 20);
            vsync = (vc == 5);
        end
    end

    // Single-port synchronous SRAM, preloaded with its own address
    logic [DATA_W-1:0] sram_mem [WORDS];
    initial begin
        for (int i = 0; i < WORDS; i++) sram_mem[i] = DATA_W'(i);
        forever begin
            @(posedge clock);
            if (sram_en) begin
                if (sram_we) sram_mem[sram_addr[5:0]] = sram_wdata;
                else         sram_rdata <= sram_mem[sram_addr[5:0]];
            end
        end
    end

    typedef struct packed {
        logic [2:0] sync;
        logic [8:0] pix;
    } ent_t;

    // Reference model and per-cycle compare
    logic [DATA_W-1:0] ref_mem [WORDS];
    initial begin : compare
        ent_t        pipe_q[$];
        ent_t        head, e;
        int          reads, ea, issue_cyc;
        logic        vs_prev, issued, m_we, exp_ack, wrap_armed, first_rd;
        logic [8:0]  m_rd;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = DATA_W'(i);
        reads = 0; issue_cyc = 0; vs_prev = 1'b0; issued = 1'b0; m_we = 1'b0;
        m_rd = '0; wrap_armed = 1'b0; first_rd = 1'b1;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset_n) begin
                chk("rst_pixel", {red, green, blue}, 32'd0);
                chk("rst_sync", {hsync_o, vsync_o, blank_o}, 32'd0);
                chk("rst_ack", host_ack, 32'd0);
                chk("rst_rdata", host_rdata, 32'd0);
                chk("rst_sram_en", sram_en, 32'd0);
                reads = 0; vs_prev = 1'b0; issued = 1'b0;
                wrap_armed = 1'b0; first_rd = 1'b1;
                pipe_q = {};
                e = '0;
                pipe_q.push_back(e);
                pipe_q.push_back(e);
            end else begin
                head = pipe_q.pop_front();
                chk("pixel", {red, green, blue}, head.pix);
                chk("sync_o", {hsync_o, vsync_o, blank_o}, head.sync);
                ea = reads % WORDS;
                if (!blank) begin
                    chk("disp_en", sram_en, 32'd1);
                    chk("disp_we", sram_we, 32'd0);
                    chk("disp_addr", sram_addr, ea);
                    if (first_rd) chk("first_rd_addr0", sram_addr, 32'd0);
                    if (wrap_armed) chk("wrap_to_0", sram_addr, 32'd0);
                    wrap_armed = (sram_addr == 19'd63);
                    first_rd = 1'b0;
                end else if (host_req && !issued) begin
                    chk("host_en", sram_en, 32'd1);
                    chk("host_we", sram_we, host_we);
                    chk("host_addr", sram_addr, host_addr);
                    if (host_we) chk("host_wdata", sram_wdata, host_wdata);
                end else begin
                    chk("idle_en", sram_en, 32'd0);
                end
                exp_ack = issued && ((cyc - issue_cyc) >= (m_we ? 1 : 2));
                chk("host_ack", host_ack, exp_ack);
                if (exp_ack && !m_we) chk("host_rdata", host_rdata, m_rd);
                e.sync = {hsync, vsync, blank};
                e.pix  = blank ? 9'd0 : ref_mem[ea];
                pipe_q.push_back(e);
                if (blank && host_req && !issued) begin
                    issued = 1'b1;
                    issue_cyc = cyc;
                    m_we = host_we;
                    if (host_we) ref_mem[host_addr[5:0]] = host_wdata;
                    else         m_rd = ref_mem[host_addr[5:0]];
                end
                if (!host_req) issued = 1'b0;
                if (!blank) reads++;
                if (vsync && !vs_prev) reads = 0;
                vs_prev = vsync;
            end
        end
    end

    task automatic host_op(input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] rd);
        int k;
        @(posedge clock);
        #1;
        host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
        k = 0;
        while (k < 400) begin
            @(negedge clock);
            if (host_ack) break;
            k++;
        end
        chk("ack_seen", host_ack, 32'd1);
        rd = host_rdata;
        @(posedge clock);
        #1;
        host_req = 1'b0;
    endtask

    task automatic random_ops(input int n);
        logic [DATA_W-1:0] rd;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 25)) @(posedge clock);
            host_op(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, WORDS - 1)),
                    DATA_W'($urandom), rd);
        end
    endtask

    initial begin : main
        logic [DATA_W-1:0] rd;
        int k;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("pin_rst_rgb", {red, green, blue}, 32'h0);
        chk("pin_rst_ack", host_ack, 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Write 5 = 1C7 in vertical blanking, then read it back
        k = 0;
        @(negedge clock);
        while (!(vc == V_ACT && hc == 0) && k < 500) begin @(negedge clock); k++; end
        host_op(1'b1, 19'd5, 9'h1C7, rd);
        host_op(1'b0, 19'd5, 9'h000, rd);
        chk("pin_readback_1c7", rd, 32'h1C7);

        // Request raised mid active video must wait for blanking
        k = 0;
        @(negedge clock);
        while (!(!blank && hc == 2) && k < 500) begin @(negedge clock); k++; end
        host_op(1'b0, 19'd17, 9'h000, rd);
        chk("pin_read17", rd, 32'd17);

        // Host read issued in the last blanking cycle before active video
        k = 0;
        @(negedge clock);
        while (!(hc == H_TOT - 2 && ((vc + 1) % V_TOT) < V_ACT) && k < 500) begin
            @(negedge clock); k++;
        end
        host_op(1'b0, 19'd5, 9'h000, rd);
        chk("pin_lastblank_read", rd, 32'h1C7);

        random_ops(40);

        // Mid-frame reset, 3 cycles low
        k = 0;
        @(negedge clock);
        while (!(!blank && vc == 1 && hc == 5) && k < 500) begin @(negedge clock); k++; end
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;

        random_ops(40);
        repeat (300) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
